div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle iterative divider and its sequencer for DIV/DIVU in the execute stage of the 5-stage MIPS pipeline.
- Produces the divide stall consumed by the hazard unit, which freezes F/D/E while the divide runs.
- Computes the quotient and remainder with a radix-2 restoring algorithm.
- Delivers HI (remainder) and LO (quotient) with a one-cycle valid pulse for the HI/LO register write.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  a DIV/DIVU is in the E stage (held by the pipeline while stalled).
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE.
- opa  input  WIDTH  dividend (rs value after forwarding); sampled in IDLE.
- opb  input  WIDTH  divisor (rt value after forwarding); sampled in IDLE.
- annul  input  1  flush/exception cancel of the E-stage instruction.
- stall_div  output  1  combinational request to stall F/D/E.
- result_valid  output  1  one-cycle pulse; hi/lo hold the new result.
- hi  output  WIDTH  remainder, registered, held until the next result.
- lo  output  WIDTH  quotient, registered, held until the next result.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE, count = 0, hi = lo = 0, result_valid = 0. stall_div and busy are low while rst is high.
- States: IDLE, RUN, DONE.
- IDLE with start=1, annul=0:
  - Capture |opa| and |opb| (absolute values only when signed_div=1).
  - Record the quotient sign (opa[MSB] ^ opb[MSB]) and the remainder sign (opa[MSB]), both gated by signed_div.
  - Clear the partial remainder and set count = 0.
  - If opb == 0, go to DONE with lo_next = all ones and hi_next = opa unmodified. Otherwise go to RUN.
- RUN, one quotient bit per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem (WIDTH+1-bit difference). If the result is non-negative, keep it and set the quotient LSB to 1.
  - Increment count. After the cycle with count == WIDTH-1, go to DONE.
- DONE:
  - Apply sign fixup: negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
  - Register hi and lo, assert result_valid for this cycle, then go to IDLE unconditionally.
  - start is ignored in DONE; the same instruction leaves E at the end of this cycle.
- stall_div = (IDLE & start & ~annul) | RUN.
  - stall_div is low in DONE so the pipeline advances in the same cycle as the HI/LO write.
  - Total stall = WIDTH+1 cycles (33) for a non-zero divisor; 1 cycle for a zero divisor.
- annul=1 in any non-IDLE state: next state is IDLE, stall_div is low in that cycle, there is no result_valid, and hi/lo are unchanged. annul has priority over count completion and over DONE.
- Overflow: -2^31 / -1 gives lo = 0x80000000, hi = 0. This falls out of the unsigned magnitude path; no special case.
- Width rule: magnitudes are unsigned WIDTH bits, so |-2^(WIDTH-1)| is representable. The partial remainder is WIDTH+1 bits.
- Back-to-back divides: the new start is accepted in the IDLE cycle that follows DONE.
- Reset asserted mid-RUN: the operation is abandoned and hi/lo return to 0.

Test Plan:
- DIVU 100/7, start held: stall_div high for exactly 33 cycles, then DONE with result_valid=1, lo=14, hi=2, stall_div=0.
- DIV -7/2 (0xFFFFFFF9 / 0x2): lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2: lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. DIVU 0xFFFFFFFF/1: lo=0xFFFFFFFF, hi=0.
- Divide by zero, opa=0x1234: stall_div for 1 cycle, next cycle result_valid with lo=0xFFFFFFFF, hi=0x1234.
- Annul at RUN cycle 10 (prior hi/lo = 14/2): stall_div drops that cycle, state is IDLE next, no result_valid, hi/lo stay 14/2.
- Reset pulse mid-RUN: immediate IDLE, hi=lo=0. A subsequent 9/3 completes with lo=3, hi=0; a back-to-back 8/4 then starts in the cycle after DONE.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between the execute stage and the iterative divider.
// The pipeline side is the master; the divider is the slave.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             annul;
    logic             stall_div;
    logic             result_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output start, signed_div, opa, opb, annul,
        input  stall_div, result_valid, hi, lo, busy
    );

    modport slave (
        input  start, signed_div, opa, opb, annul,
        output stall_div, result_valid, hi, lo, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider with its own sequencer for DIV/DIVU.
// Works on magnitudes, one quotient bit per cycle, and fixes up the
// signs when the result is presented. While the divide runs it raises
// stall_div so the hazard unit freezes F/D/E; the HI/LO write happens in
// the DONE cycle, the same cycle the instruction leaves E.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;      // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvsr;     // divisor magnitude
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             commit;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;  // WIDTH+1-bit shifted partial remainder
    logic [WIDTH-1:0] diff;
    logic             take;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    // A new divide is taken only from IDLE and only if not being flushed.
    assign accept = (state == IDLE) && bus.start && !bus.annul;
    // The result is delivered in DONE unless the instruction is cancelled.
    assign commit = (state == DONE) && !bus.annul;

    assign abs_a = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign abs_b = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

    // Trial subtraction: the difference fits in WIDTH bits whenever it is
    // non-negative, so only the low bits are kept and the sign comes from
    // the full-width compare.
    assign shifted = {rem, quo[WIDTH-1]};
    assign take    = (shifted >= {1'b0, dvsr});
    assign diff    = shifted[WIDTH-1:0] - dvsr;

    assign hi_fix = r_neg ? -rem : rem;
    assign lo_fix = q_neg ? -quo : quo;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state <= state_next;
        end
    end

    // Next-state and pipeline-facing outputs; annul beats completion.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next       = state;
        bus.stall_div    = 1'b0;
        bus.busy         = 1'b0;
        bus.result_valid = 1'b0;
        bus.hi           = hi_q;
        bus.lo           = lo_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.opb == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.annul) begin
                    state_next = IDLE;
                end else if (count == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!rst) begin
            bus.stall_div = accept || ((state == RUN) && !bus.annul);
            bus.busy      = (state != IDLE);
        end
        if (commit) begin
            bus.result_valid = 1'b1;
            bus.hi           = hi_fix;
            bus.lo           = lo_fix;
        end
    end

    // Datapath: operand capture, one restoring step per RUN cycle, HI/LO commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count <= '0;
                        dvsr  <= abs_b;
                        if (bus.opb == '0) begin
                            // Divide by zero: all-ones quotient, raw dividend
                            // as remainder, no sign fixup.
                            quo   <= '1;
                            rem   <= bus.opa;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end else begin
                            quo   <= abs_a;
                            rem   <= '0;
                            q_neg <= bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                            r_neg <= bus.signed_div & bus.opa[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    quo   <= {quo[WIDTH-2:0], take};
                    rem   <= take ? diff : shifted[WIDTH-1:0];
                    count <= count + 1'b1;
                end
                DONE: begin
                    if (commit) begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: unsigned/signed divides, divide by
// zero, annul mid-run, reset mid-run and back-to-back divides.
module tb_div_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a divide from IDLE and counts stall cycles until stall_div
    // drops; returns what the outputs show in that first non-stall cycle.
    task automatic drive_div(input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, output int ncyc, output logic v,
                             output logic st, output logic [31:0] h,
                             output logic [31:0] l);
        bus.opa        = a;
        bus.opb        = b;
        bus.signed_div = sgn;
        bus.annul      = 1'b0;
        bus.start      = 1'b1;
        #1;
        ncyc = 0;
        while (bus.stall_div && ncyc < 100) begin
            ncyc++;
            tick();
        end
        v  = bus.result_valid;
        st = bus.stall_div;
        h  = bus.hi;
        l  = bus.lo;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opa        = 32'd100;
        bus.opb        = 32'd7;
        bus.annul      = 1'b0;
        #3;
        checks++;
        if (bus.stall_div !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_div); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++;
        if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.result_valid); end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_divu();
        int          n;
        logic        v, st;
        logic [31:0] h, l;
        drive_div(32'd100, 32'd7, 1'b0, n, v, st, h, l);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 33", n); end
        checks++;
        if (v !== 1'b1 || st !== 1'b0) begin errors++; $display("FAIL divu_done: got valid=%b stall=%b want 1/0", v, st); end
        checks++;
        if (l !== 32'd14 || h !== 32'd2) begin errors++; $display("FAIL divu_result: got lo=%0d hi=%0d want 14/2", l, h); end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL divu_after_done: got valid=%b busy=%b want 0/0", bus.result_valid, bus.busy);
        end
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hold: got lo=%0d hi=%0d want 14/2", bus.lo, bus.hi); end
    endtask

    task automatic test_annul();
        int saw_valid;
        bus.opa        = 32'd100;
        bus.opb        = 32'd7;
        bus.signed_div = 1'b0;
        bus.annul      = 1'b0;
        bus.start      = 1'b1;
        tick();                 // now RUN, count 0
        repeat (10) tick();     // RUN, count 10
        bus.annul = 1'b1;
        #1;
        checks++;
        if (bus.stall_div !== 1'b0) begin errors++; $display("FAIL annul_stall: got %b want 0", bus.stall_div); end
        tick();
        bus.start = 1'b0;
        bus.annul = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL annul_idle: got busy=%b want 0", bus.busy); end
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.result_valid === 1'b1) saw_valid++;
            tick();
        end
        checks++;
        if (saw_valid !== 0) begin errors++; $display("FAIL annul_no_valid: got %0d pulses want 0", saw_valid); end
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin errors++; $display("FAIL annul_hold: got lo=%0d hi=%0d want 14/2", bus.lo, bus.hi); end
    endtask

    task automatic test_signed();
        logic [31:0] va [4] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] vb [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001};
        logic        vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] el [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] eh [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000};
        int          n;
        logic        v, st;
        logic [31:0] h, l;
        for (int i = 0; i < 4; i++) begin
            drive_div(va[i], vb[i], vs[i], n, v, st, h, l);
            checks++;
            if (n !== 33 || v !== 1'b1) begin
                errors++; $display("FAIL signed_%0d_timing: got cycles=%0d valid=%b want 33/1", i, n, v);
            end
            checks++;
            if (l !== el[i] || h !== eh[i]) begin
                errors++; $display("FAIL signed_%0d_result: got lo=%h hi=%h want %h/%h", i, l, h, el[i], eh[i]);
            end
            bus.start = 1'b0;
            tick();
        end
    endtask

    task automatic test_div_zero();
        int          n;
        logic        v, st;
        logic [31:0] h, l;
        drive_div(32'h1234, 32'h0, 1'b1, n, v, st, h, l);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL divzero_stall_cycles: got %0d want 1", n); end
        checks++;
        if (v !== 1'b1 || l !== 32'hFFFFFFFF || h !== 32'h1234) begin
            errors++; $display("FAIL divzero_result: got valid=%b lo=%h hi=%h want 1/ffffffff/00001234", v, l, h);
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int          n;
        logic        v, st;
        logic [31:0] h, l;
        bus.opa        = 32'd100;
        bus.opb        = 32'd7;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        repeat (6) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall_div !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: got busy=%b stall=%b want 0/0", bus.busy, bus.stall_div);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo); end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive_div(32'd9, 32'd3, 1'b0, n, v, st, h, l);
        checks++;
        if (n !== 33 || v !== 1'b1 || l !== 32'd3 || h !== 32'd0) begin
            errors++; $display("FAIL after_rst_div: got cycles=%0d valid=%b lo=%0d hi=%0d want 33/1/3/0", n, v, l, h);
        end
        // Back-to-back: new operands presented while in DONE, start held.
        bus.opa = 32'd8;
        bus.opb = 32'd4;
        tick();
        checks++;
        if (bus.stall_div !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got stall=%b busy=%b want 1/0", bus.stall_div, bus.busy);
        end
        drive_div(32'd8, 32'd4, 1'b0, n, v, st, h, l);
        checks++;
        if (n !== 33 || v !== 1'b1 || l !== 32'd2 || h !== 32'd0) begin
            errors++; $display("FAIL b2b_result: got cycles=%0d valid=%b lo=%0d hi=%0d want 33/1/2/0", n, v, l, h);
        end
        bus.start = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_divu();
        test_annul();
        test_signed();
        test_div_zero();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
